sitcp_tx_mux: RTL



---
 rtl/sitcp_tx_mux.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sitcp_tx_mux.sv
// Packet-atomic N-channel merger feeding the SiTCP TX byte port.
// Round-robin over complete packets, MSB-first serialisation, optional A5/ch ... 5A/wcnt framing.
module sitcp_tx_mux #(
    parameter int NCH       = 4,
    parameter int IN_W      = 32,
    parameter int DEPTH     = 512,
    parameter int HDR_EN    = 1,
    parameter int AF_MARGIN = 16
) (
    input  logic                CLK_200M,
    input  logic                SYS_RSTn,
    input  logic                SRST,
    input  logic [NCH*IN_W-1:0] CH_DATA,
    input  logic [NCH-1:0]      CH_WE,
    input  logic [NCH-1:0]      CH_LAST,
    output logic [NCH-1:0]      CH_AFULL,
    output logic [NCH-1:0]      CH_OVF,
    input  logic                TCP_TX_FULL,
    output logic                TCP_TX_WR,
    output logic [7:0]          TCP_TX_DATA,
    output logic                TX_BUSY,
    output logic [3:0]          CUR_CH
);
    localparam int AW       = $clog2(DEPTH);
    localparam int NB       = IN_W / 8;
    localparam int BW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AF_TH_I  = DEPTH - AF_MARGIN;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   AF_TH    = AF_TH_I[AW:0];
    localparam logic [BW-1:0] LAST_B   = BW'(NB - 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, TRL0, TRL1, TRL2} state_t;

    logic [IN_W:0]   mem [NCH][DEPTH];
    logic [AW-1:0]   wr_q [NCH], wr_d [NCH], rd_q [NCH], rd_d [NCH];
    logic [AW:0]     cnt_q [NCH], cnt_d [NCH], pkt_q [NCH], pkt_d [NCH];
    logic [IN_W:0]   head [NCH];
    logic [NCH-1:0]  afull_q, afull_d, ovf_q, ovf_d;
    logic [NCH-1:0]  full, push, pop, elig;

    state_t          state_q;
    logic [3:0]      cur_q, ptr_q, gnt_ch, nxt_ptr;
    logic [BW-1:0]   bidx_q;
    logic [15:0]     wcnt_q;
    logic            trunc_q, flush_q, tx_wr_q, busy_q, gnt_hit;
    logic [7:0]      tx_data_q, pay_byte;
    logic [IN_W:0]   cur_head;
    logic [IN_W-1:0] shifted;
    logic            last_byte, pop_cur, flush_empty;

    always_comb begin
        cur_head    = head[cur_q[CW-1:0]];
        shifted     = cur_head[IN_W-1:0] << {bidx_q, 3'b000};
        pay_byte    = shifted[IN_W-1 -: 8];
        last_byte   = (bidx_q == LAST_B);
        pop_cur     = (state_q == PAY) && !TCP_TX_FULL && last_byte;
        // a forced flush ends once the buffer drains with nothing arriving behind it
        flush_empty = flush_q && (cnt_q[cur_q[CW-1:0]] == (AW+1)'(1)) && !push[cur_q[CW-1:0]];
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            full[k]    = (cnt_q[k] == FULL_CNT);
            push[k]    = CH_WE[k] && !full[k];
            pop[k]     = pop_cur && (cur_q[CW-1:0] == CW'(k));
            head[k]    = mem[k][rd_q[k]];
            elig[k]    = (pkt_q[k] != '0) || full[k];
            wr_d[k]    = wr_q[k] + AW'(push[k]);
            rd_d[k]    = rd_q[k] + AW'(pop[k]);
            cnt_d[k]   = cnt_q[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
            pkt_d[k]   = pkt_q[k] + (AW+1)'(push[k] && CH_LAST[k])
                                  - (AW+1)'(pop[k] && head[k][IN_W]);
            afull_d[k] = (cnt_d[k] >= AF_TH);
            ovf_d[k]   = ovf_q[k] | (CH_WE[k] & full[k]);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        gnt_hit = 1'b0;
        gnt_ch  = 4'd0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_hit && elig[idx]) begin
                gnt_hit = 1'b1;
                gnt_ch  = 4'(idx);
            end
        end
        nxt_ptr = (gnt_ch == 4'(NCH - 1)) ? 4'd0 : gnt_ch + 4'd1;
    end

    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            for (int k = 0; k < NCH; k++) begin
                wr_q[k] <= '0; rd_q[k] <= '0; cnt_q[k] <= '0; pkt_q[k] <= '0;
            end
            afull_q <= '0;
            ovf_q   <= '0;
        end else if (SRST) begin
            for (int k = 0; k < NCH; k++) begin
                wr_q[k] <= '0; rd_q[k] <= '0; cnt_q[k] <= '0; pkt_q[k] <= '0;
            end
            afull_q <= '0;
            ovf_q   <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                wr_q[k] <= wr_d[k]; rd_q[k] <= rd_d[k]; cnt_q[k] <= cnt_d[k]; pkt_q[k] <= pkt_d[k];
            end
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK_200M) begin
        for (int k = 0; k < NCH; k++)
            if (push[k]) mem[k][wr_q[k]] <= {CH_LAST[k], CH_DATA[k*IN_W +: IN_W]};
    end

    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q <= IDLE; cur_q <= 4'd0; ptr_q <= 4'd0; bidx_q <= '0; wcnt_q <= 16'd0;
            trunc_q <= 1'b0; flush_q <= 1'b0; tx_wr_q <= 1'b0; tx_data_q <= 8'd0; busy_q <= 1'b0;
        end else if (SRST) begin
            state_q <= IDLE; cur_q <= 4'd0; ptr_q <= 4'd0; bidx_q <= '0; wcnt_q <= 16'd0;
            trunc_q <= 1'b0; flush_q <= 1'b0; tx_wr_q <= 1'b0; tx_data_q <= 8'd0; busy_q <= 1'b0;
        end else begin
            tx_wr_q <= 1'b0;
            if (state_q == IDLE) busy_q <= 1'b0;
            if (!TCP_TX_FULL) begin
                case (state_q)
                    IDLE: if (gnt_hit) begin
                        cur_q   <= gnt_ch;
                        ptr_q   <= nxt_ptr;
                        busy_q  <= 1'b1;
                        wcnt_q  <= 16'd0;
                        bidx_q  <= '0;
                        trunc_q <= 1'b0;
                        flush_q <= (pkt_q[gnt_ch[CW-1:0]] == '0);
                        state_q <= (HDR_EN != 0) ? HDR0 : PAY;
                    end
                    HDR0: begin
                        tx_wr_q <= 1'b1; tx_data_q <= 8'hA5; state_q <= HDR1;
                    end
                    HDR1: begin
                        tx_wr_q <= 1'b1; tx_data_q <= {4'h0, cur_q}; state_q <= PAY;
                    end
                    PAY: begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= pay_byte;
                        if (last_byte) begin
                            bidx_q <= '0;
                            wcnt_q <= wcnt_q + 16'd1;
                            if (cur_head[IN_W]) begin
                                state_q <= (HDR_EN != 0) ? TRL0 : IDLE;
                            end else if (flush_empty) begin
                                trunc_q <= 1'b1;
                                state_q <= (HDR_EN != 0) ? TRL0 : IDLE;
                            end
                        end else begin
                            bidx_q <= bidx_q + BW'(1);
                        end
                    end
                    TRL0: begin
                        tx_wr_q <= 1'b1; tx_data_q <= trunc_q ? 8'h5B : 8'h5A; state_q <= TRL1;
                    end
                    TRL1: begin
                        tx_wr_q <= 1'b1; tx_data_q <= wcnt_q[15:8]; state_q <= TRL2;
                    end
                    TRL2: begin
                        tx_wr_q <= 1'b1; tx_data_q <= wcnt_q[7:0]; state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign CH_AFULL    = afull_q;
    assign CH_OVF      = ovf_q;
    assign TCP_TX_WR   = tx_wr_q;
    assign TCP_TX_DATA = tx_data_q;
    assign TX_BUSY     = busy_q;
    assign CUR_CH      = cur_q;
endmodule
